// File: rtl/pcu_pkg.sv
// Shared encodings for the phase control unit: opcodes, command codes,
// FSM states and the datapath control vector.
package pcu_pkg;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_BR  = 2'b10,
    OP_ALU = 2'b11
  } op_e;

  typedef enum logic [4:0] {
    CMD_NOP = 5'd0, CMD_ARITH, CMD_CMP, CMD_MOV, CMD_IN, CMD_OUT,
    CMD_HLT, CMD_LD, CMD_ST, CMD_LI, CMD_JMP
  } cmd_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_e;

  typedef struct packed {
    logic       aluc_e, ar_e, br_e, dr_e, mdr_e, ir_e, reg_e;
    logic       genr_w, mem_e, mem_w, jump, out_s;
    logic [6:0] mux_s;   // {m8,m7,m6,m5,m4,m3,m2}
  } ctrl_t;

  localparam int CTRL_W  = $bits(ctrl_t);
  localparam int ALU_LSB = 4;

  // alu_op sub-codes (op == OP_ALU)
  localparam logic [3:0] AO_ADD = 4'd0,  AO_SUB = 4'd1,  AO_AND = 4'd2,  AO_OR  = 4'd3;
  localparam logic [3:0] AO_XOR = 4'd4,  AO_CMP = 4'd5,  AO_MOV = 4'd6,  AO_SLL = 4'd7;
  localparam logic [3:0] AO_SRL = 4'd8,  AO_SRA = 4'd9,  AO_IN  = 4'd10, AO_OUT = 4'd11;
  localparam logic [3:0] AO_HLT = 4'd12;

  // r1 sub-codes (op == OP_BR)
  localparam logic [2:0] BR_LI = 3'd0, BR_B = 3'd1, BR_BE = 3'd2, BR_BLT = 3'd3;
  localparam logic [2:0] BR_BLE = 3'd4, BR_BNE = 3'd5;

  localparam logic [6:0] M2 = 7'b0000001, M3 = 7'b0000010, M4 = 7'b0000100;
  localparam logic [6:0] M5 = 7'b0001000, M6 = 7'b0010000, M7 = 7'b0100000;
  localparam logic [6:0] M8 = 7'b1000000;

  localparam ctrl_t CTRL_NOP = '{reg_e: 1'b1, default: '0};

  function automatic ctrl_t cmd_ctrl(cmd_e c);
    ctrl_t v;
    v = '0;
    case (c)
      CMD_ARITH: begin v.aluc_e = 1'b1; v.ar_e = 1'b1; v.br_e = 1'b1; v.dr_e = 1'b1;
                       v.genr_w = 1'b1; v.mux_s = M2; end
      CMD_CMP:   begin v.aluc_e = 1'b1; v.ar_e = 1'b1; v.br_e = 1'b1; end
      CMD_MOV:   begin v.br_e = 1'b1; v.dr_e = 1'b1; v.genr_w = 1'b1; v.mux_s = M4; end
      CMD_IN:    begin v.dr_e = 1'b1; v.genr_w = 1'b1; v.mux_s = M5; end
      CMD_OUT:   begin v.ar_e = 1'b1; v.out_s = 1'b1; end
      CMD_HLT:   v = '0;
      CMD_LD:    begin v.ar_e = 1'b1; v.mem_e = 1'b1; v.mdr_e = 1'b1; v.dr_e = 1'b1;
                       v.genr_w = 1'b1; v.mux_s = M6; end
      CMD_ST:    begin v.ar_e = 1'b1; v.br_e = 1'b1; v.mem_e = 1'b1; v.mem_w = 1'b1;
                       v.mux_s = M7; end
      CMD_LI:    begin v.dr_e = 1'b1; v.genr_w = 1'b1; v.mux_s = M8; end
      CMD_JMP:   begin v.jump = 1'b1; v.mux_s = M3; end
      default:   v = CTRL_NOP;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/phase_control_unit_decode.sv
// Combinational decode of the latched IR fields and flags into a control vector.
// Untaken branches and undefined codes fall through to the NOP vector.
module pcu_decode
  import pcu_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [2:0]        r1,
  input  logic [3:0]        alu_op,
  input  logic              s,
  input  logic              z,
  input  logic              v,
  output logic [CTRL_W-1:0] ctrl,
  output logic              is_hlt
);

  cmd_e cmd;

  always_comb begin
    cmd = CMD_NOP;
    case (op_e'(op))
      OP_LD: cmd = CMD_LD;
      OP_ST: cmd = CMD_ST;
      OP_BR: begin
        case (r1)
          BR_LI:  cmd = CMD_LI;
          BR_B:   cmd = CMD_JMP;
          BR_BE:  if (z)             cmd = CMD_JMP;
          BR_BLT: if (s ^ v)         cmd = CMD_JMP;
          BR_BLE: if (z | (s ^ v))   cmd = CMD_JMP;
          BR_BNE: if (!z)            cmd = CMD_JMP;
          default: cmd = CMD_NOP;
        endcase
      end
      OP_ALU: begin
        case (alu_op)
          AO_ADD, AO_SUB, AO_AND, AO_OR, AO_XOR,
          AO_SLL, AO_SRL, AO_SRA: cmd = CMD_ARITH;
          AO_CMP:  cmd = CMD_CMP;
          AO_MOV:  cmd = CMD_MOV;
          AO_IN:   cmd = CMD_IN;
          AO_OUT:  cmd = CMD_OUT;
          AO_HLT:  cmd = CMD_HLT;
          default: cmd = CMD_NOP;
        endcase
      end
      default: cmd = CMD_NOP;
    endcase
  end

  assign ctrl   = cmd_ctrl(cmd);
  assign is_hlt = (cmd == CMD_HLT);

endmodule

// File: rtl/phase_control_unit.sv
// Sequential control unit: phase counter, latched IR/flags, memory-wait stall
// with bus-error timeout, HLT/resume handshake and retired-instruction count.
module phase_control_unit
  import pcu_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int NPHASE     = 6,
  parameter int MEM_PHASE  = 4,
  parameter int WB_PHASE   = 5,
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               S,
  input  logic               Z,
  input  logic               C,
  input  logic               V,
  input  logic               mem_rdy,
  output logic               aluc_e,
  output logic               ar_e,
  output logic               br_e,
  output logic               dr_e,
  output logic               mdr_e,
  output logic               ir_e,
  output logic               reg_e,
  output logic               genr_w,
  output logic               mem_e,
  output logic               mem_w,
  output logic               jump,
  output logic               out_s,
  output logic [6:0]         mux_s,
  output logic [5:0]         alu_instruction,
  output logic [2:0]         phase,
  output logic               hlt,
  output logic               bus_err,
  output logic [CNT_W-1:0]   retired
);

  localparam int         WC_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [2:0] LAST = 3'(NPHASE - 1);
  localparam logic [2:0] MEMP = 3'(MEM_PHASE);
  localparam logic [2:0] WBP  = 3'(WB_PHASE);

  state_e              state, state_nx;
  logic [2:0]          phase_nx;
  logic [WC_W-1:0]     wait_cnt, wait_nx;
  logic [INSTR_W-1:0]  ir_q;
  logic                s_q, z_q, v_q;
  logic                retire, set_err, stall, dec_hlt, active;
  logic [CTRL_W-1:0]   dec_raw;
  ctrl_t               dec, ctl;
  logic [5:0]          alu_instr;
  logic                unused_in;

  assign unused_in = ^{C, ir_q[ALU_LSB-1:0]};

  pcu_decode u_dec (
    .op     (ir_q[INSTR_W-1 -: 2]),
    .r1     (ir_q[INSTR_W-3 -: 3]),
    .alu_op (ir_q[ALU_LSB +: 4]),
    .s      (s_q),
    .z      (z_q),
    .v      (v_q),
    .ctrl   (dec_raw),
    .is_hlt (dec_hlt)
  );

  assign dec    = ctrl_t'(dec_raw);
  assign active = (state == S_RUN) || (state == S_WAIT);
  assign stall  = active && (phase == MEMP) && dec.mem_e && !mem_rdy;

  // Phase 0 is dead, phase 1 fetches, later phases carry the gated decode.
  always_comb begin
    ctl       = '0;
    alu_instr = '0;
    if (active) begin
      if (phase == 3'd1) begin
        ctl.ir_e = 1'b1;
      end else if (phase >= 3'd2) begin
        ctl        = dec;
        ctl.genr_w = dec.genr_w & (phase == WBP);
        ctl.mem_w  = dec.mem_w & (phase == MEMP);
        alu_instr  = (ir_q[INSTR_W-1 -: 2] == 2'b11) ? {ir_q[INSTR_W-1 -: 2], ir_q[ALU_LSB +: 4]}
                                                     : ir_q[INSTR_W-1 -: 6];
      end
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    wait_nx  = wait_cnt;
    retire   = 1'b0;
    set_err  = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_nx = S_RUN;
          phase_nx = '0;
        end
      end
      S_RUN, S_WAIT: begin
        if (stall) begin
          if (wait_cnt == WC_W'(WAIT_LIMIT - 1)) begin
            state_nx = S_HALT;
            set_err  = 1'b1;
            wait_nx  = '0;
          end else begin
            state_nx = S_WAIT;
            wait_nx  = wait_cnt + WC_W'(1);
          end
        end else if (state == S_RUN && phase == 3'd2 && dec_hlt) begin
          state_nx = S_HALT;
          retire   = 1'b1;
        end else begin
          state_nx = S_RUN;
          wait_nx  = '0;
          if (phase == LAST) begin
            phase_nx = '0;
            retire   = 1'b1;
          end else begin
            phase_nx = phase + 3'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      wait_cnt <= '0;
      ir_q     <= '0;
      s_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      hlt      <= 1'b0;
      bus_err  <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      wait_cnt <= wait_nx;
      hlt      <= (state_nx == S_HALT);
      if (set_err) bus_err <= 1'b1;
      if (retire)  retired <= retired + CNT_W'(1);
      if (state == S_RUN && phase == 3'd1) begin
        ir_q <= instruction;
        s_q  <= S;
        z_q  <= Z;
        v_q  <= V;
      end
    end
  end

  assign aluc_e          = ctl.aluc_e;
  assign ar_e            = ctl.ar_e;
  assign br_e            = ctl.br_e;
  assign dr_e            = ctl.dr_e;
  assign mdr_e           = ctl.mdr_e;
  assign ir_e            = ctl.ir_e;
  assign reg_e           = ctl.reg_e;
  assign genr_w          = ctl.genr_w;
  assign mem_e           = ctl.mem_e;
  assign mem_w           = ctl.mem_w;
  assign jump            = ctl.jump;
  assign out_s           = ctl.out_s;
  assign mux_s           = ctl.mux_s;
  assign alu_instruction = alu_instr;

endmodule
